// File: rtl/matrix_scan_capture_pkg.sv
// Shared definitions for the LED-matrix scan capture block: default matrix
// size, capture FSM encodings and a one-hot decoder that the display side
// can reuse.
package matrix_scan_capture_pkg;

  localparam int GS_DEF   = 8;
  localparam int ONEHOT_W = 32;  // widest row select the decoder handles

  typedef enum logic [1:0] {
    ST_WAIT0 = 2'd0,
    ST_CAPT  = 2'd1,
    ST_PUB   = 2'd2
  } state_e;

  typedef struct packed {
    logic       valid;  // exactly one bit set
    logic [4:0] idx;    // position of the set bit (meaningful when valid)
  } onehot_t;

  // Decode a one-hot vector into an index; valid is 0 for zero or multi-hot.
  function automatic onehot_t onehot_to_idx(input logic [ONEHOT_W-1:0] v);
    onehot_t r;
    r.valid = (v != '0) && ((v & (v - 32'd1)) == '0);
    r.idx   = '0;
    for (int i = 0; i < ONEHOT_W; i++) begin
      if (v[i]) r.idx = 5'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/matrix_scan_capture_if.sv
// Bus between the LED-matrix scan source and the capture block.
//
// Handshake: there is no backpressure. The scan side drives row_val_i /
// col_val_i freely every cycle; the capture side qualifies frame_o with the
// one-cycle strobe frame_valid_o (frame_o is stable between strobes) and
// flags discarded frames with the one-cycle strobe seq_err_o. state_dbg
// mirrors the capture FSM state.
interface matrix_scan_capture_if
  import matrix_scan_capture_pkg::*;
#(
  parameter int GS = GS_DEF
);
  logic [GS-1:0]    row_val_i;
  logic [GS-1:0]    col_val_i;
  logic [GS*GS-1:0] frame_o;
  logic             frame_valid_o;
  logic             seq_err_o;
  logic [7:0]       frame_cnt_o;
  state_e           state_dbg;

  modport master (
    output row_val_i, col_val_i,
    input  frame_o, frame_valid_o, seq_err_o, frame_cnt_o, state_dbg
  );

  modport slave (
    input  row_val_i, col_val_i,
    output frame_o, frame_valid_o, seq_err_o, frame_cnt_o, state_dbg
  );
endinterface

// File: rtl/matrix_scan_capture_scan_sample_stab.sv
// Input stage: registers the scan lines once and emits a single accept
// pulse per stable episode once the sample has held for HOLD_MIN cycles.
module scan_sample_stab #(
  parameter int GS       = 8,
  parameter int HOLD_MIN = 2
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          en_i,
  input  logic [GS-1:0] row_val_i,
  input  logic [GS-1:0] col_val_i,
  output logic [GS-1:0] s_row,
  output logic [GS-1:0] s_col,
  output logic          accept
);

  localparam logic [3:0] HOLD_C = 4'(HOLD_MIN);
  localparam logic [3:0] ACC_C  = 4'(HOLD_MIN - 1);

  logic [3:0] stable_cnt;

  // Sample register and stability counter; counter saturates so the accept
  // value is only ever passed through once per episode.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      s_row      <= '0;
      s_col      <= '0;
      stable_cnt <= '0;
    end else if (en_i) begin
      s_row <= row_val_i;
      s_col <= col_val_i;
      if ({row_val_i, col_val_i} != {s_row, s_col}) begin
        stable_cnt <= '0;
      end else if (stable_cnt != HOLD_C) begin
        stable_cnt <= stable_cnt + 4'd1;
      end
    end
  end

  // Held while disabled, so a frozen acceptance fires when enable returns.
  assign accept = en_i && (stable_cnt == ACC_C);

endmodule

// File: rtl/matrix_scan_capture.sv
// Reassembles a GS x GS frame from a one-hot row scan. Rows must arrive in
// order 0..GS-1; out-of-order rows discard the frame. frame_o is reloaded
// on the edge that enters PUB so it lines up with the frame_valid_o strobe.
module matrix_scan_capture
  import matrix_scan_capture_pkg::*;
#(
  parameter int GS             = GS_DEF,
  parameter int HOLD_MIN       = 2,
  parameter bit COL_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  en_i,
  matrix_scan_capture_if.slave  bus
);

  localparam logic [4:0] LAST_ROW = 5'(GS - 1);

  logic [GS-1:0]    s_row, s_col, col_eff;
  logic             accept;
  onehot_t          hit;
  logic [4:0]       idx;
  logic             blank;

  state_e           state_q, state_d;
  logic [4:0]       exp_q, exp_d;
  logic [GS-1:0]    mask_q, mask_d;
  logic [GS*GS-1:0] rowbuf_q, rowbuf_d;
  logic [GS*GS-1:0] frame_q;
  logic [7:0]       cnt_q;

  logic store, restart, inc_exp, clr_mask, err, publish;

  scan_sample_stab #(.GS(GS), .HOLD_MIN(HOLD_MIN)) u_stab (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .en_i      (en_i),
    .row_val_i (bus.row_val_i),
    .col_val_i (bus.col_val_i),
    .s_row     (s_row),
    .s_col     (s_col),
    .accept    (accept)
  );

  assign col_eff = COL_ACTIVE_LOW ? ~s_col : s_col;
  assign hit     = onehot_to_idx(ONEHOT_W'(s_row));
  assign idx     = hit.idx;
  assign blank   = (s_row == '0);

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_q <= ST_WAIT0;
    else          state_q <= state_d;
  end

  // Next state and datapath controls from the classified accepted sample.
  always_comb begin
    state_d  = state_q;
    store    = 1'b0;
    restart  = 1'b0;
    inc_exp  = 1'b0;
    clr_mask = 1'b0;
    err      = 1'b0;
    publish  = 1'b0;
    unique case (state_q)
      ST_WAIT0: begin
        if (accept && hit.valid && idx == 5'd0) begin
          store   = 1'b1;
          restart = 1'b1;
          state_d = ST_CAPT;
        end
      end
      ST_CAPT: begin
        if (accept && !blank) begin
          if (!hit.valid) begin
            err      = 1'b1;
            clr_mask = 1'b1;
            state_d  = ST_WAIT0;
          end else if (idx == exp_q) begin
            store = 1'b1;
            if (idx == LAST_ROW) begin
              publish = 1'b1;
              state_d = ST_PUB;
            end else begin
              inc_exp = 1'b1;
            end
          end else if (idx == 5'd0) begin
            err      = 1'b1;
            clr_mask = 1'b1;
            store    = 1'b1;
            restart  = 1'b1;
          end else if (idx == exp_q - 5'd1) begin
            // re-scan of the row just captured: keep the first copy
          end else begin
            err      = 1'b1;
            clr_mask = 1'b1;
            state_d  = ST_WAIT0;
          end
        end
      end
      ST_PUB: begin
        if (en_i) begin
          clr_mask = 1'b1;
          state_d  = ST_WAIT0;
        end
      end
      default: state_d = ST_WAIT0;
    endcase
  end

  // Next values of expected row, row mask and row buffer.
  always_comb begin
    exp_d    = exp_q;
    mask_d   = clr_mask ? '0 : mask_q;
    rowbuf_d = rowbuf_q;
    if (restart)      exp_d = 5'd1;
    else if (inc_exp) exp_d = exp_q + 5'd1;
    if (store) begin
      mask_d[idx]              = 1'b1;
      rowbuf_d[idx*GS +: GS]   = col_eff;
    end
  end

  // Capture registers and the published frame / frame counter.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      exp_q    <= '0;
      mask_q   <= '0;
      rowbuf_q <= '0;
      frame_q  <= '0;
      cnt_q    <= '0;
    end else begin
      exp_q    <= exp_d;
      mask_q   <= mask_d;
      rowbuf_q <= rowbuf_d;
      if (publish) begin
        frame_q <= rowbuf_d;
        cnt_q   <= cnt_q + 8'd1;
      end
    end
  end

  assign bus.frame_o       = frame_q;
  assign bus.frame_cnt_o   = cnt_q;
  assign bus.frame_valid_o = en_i && (state_q == ST_PUB);
  assign bus.seq_err_o     = err;
  assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_matrix_scan_capture.sv
// Bench for matrix_scan_capture (GS=8, HOLD_MIN=2): drives row scans,
// queues the expected frames and compares them when frame_valid_o strobes.
module tb_matrix_scan_capture;
  import matrix_scan_capture_pkg::*;

  localparam int GS = 8;
  typedef logic [GS-1:0] cols_t [GS];

  logic clk_i   = 1'b0;
  logic reset_i = 1'b0;
  logic en_i    = 1'b0;

  // clock / reset
  always #5 clk_i = ~clk_i;

  matrix_scan_capture_if #(.GS(GS)) bus ();

  matrix_scan_capture #(.GS(GS), .HOLD_MIN(2), .COL_ACTIVE_LOW(1'b0)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (en_i),
    .bus     (bus)
  );

  int               cyc = 0;
  int               n_checks = 0;
  int               n_errors = 0;
  int               err_seen = 0;
  int               exp_err  = 0;
  logic [7:0]       model_cnt = '0;
  logic [GS*GS-1:0] last_frame = '0;

  logic [GS*GS-1:0] exp_q [$];
  logic [7:0]       cnt_q [$];
  int               cyc_q [$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [GS*GS-1:0] frame_of(input cols_t c);
    logic [GS*GS-1:0] f;
    for (int r = 0; r < GS; r++) f[r*GS +: GS] = c[r];
    return f;
  endfunction

  // drivers
  task automatic put(input logic [GS-1:0] row, input logic [GS-1:0] col, input int hold);
    bus.row_val_i = row;
    bus.col_val_i = col;
    repeat (hold) @(negedge clk_i);
  endtask

  task automatic rows(input cols_t c, input int first, input int last, input int hold,
                      input bit publish);
    for (int r = first; r <= last; r++) begin
      logic [GS-1:0] rv;
      rv    = '0;
      rv[r] = 1'b1;
      if (publish && r == GS - 1) begin
        model_cnt  = model_cnt + 8'd1;
        last_frame = frame_of(c);
        exp_q.push_back(last_frame);
        cnt_q.push_back(model_cnt);
        cyc_q.push_back(cyc + 3);  // register, hold 1 cycle, act, strobe
      end
      put(rv, c[r], hold);
    end
  endtask

  // scoreboard
  always @(negedge clk_i) begin
    if (reset_i) begin
      if (bus.seq_err_o) err_seen++;
      if (bus.frame_valid_o) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 64'(bus.frame_valid_o), 64'd0);
        end else begin
          check("frame", bus.frame_o, exp_q.pop_front());
          check("frame_cnt", 64'(bus.frame_cnt_o), 64'(cnt_q.pop_front()));
          check("valid_latency", 64'(cyc), 64'(cyc_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cols_t x_cols, c;
    bus.row_val_i = '0;
    bus.col_val_i = '0;
    x_cols = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81};

    // reset state
    repeat (3) @(negedge clk_i);
    check("rst_frame", bus.frame_o, '0);
    check("rst_cnt", 64'(bus.frame_cnt_o), 64'd0);
    check("rst_valid", 64'(bus.frame_valid_o), 64'd0);
    check("rst_err", 64'(bus.seq_err_o), 64'd0);
    check("rst_state", 64'(bus.state_dbg), 64'(ST_WAIT0));
    reset_i = 1'b1;
    en_i    = 1'b1;
    @(negedge clk_i);

    // clean X scan
    rows(x_cols, 0, GS - 1, 4, 1'b1);
    repeat (4) @(negedge clk_i);
    check("x_cnt", 64'(bus.frame_cnt_o), 64'(model_cnt));
    check("x_hold", bus.frame_o, last_frame);

    // one-cycle glitch on row 3 must be filtered
    c = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    rows(c, 0, 2, 4, 1'b0);
    put(8'b0000_1000, 8'hFF, 1);
    rows(c, 3, GS - 1, 4, 1'b1);
    repeat (3) @(negedge clk_i);
    check("glitch_err", 64'(err_seen), 64'(exp_err));

    // out-of-order row 5 discards, then a clean scan publishes
    rows(x_cols, 0, 2, 4, 1'b0);
    put(8'b0010_0000, 8'h33, 4);
    exp_err++;
    check("skip_err", 64'(err_seen), 64'(exp_err));
    check("skip_state", 64'(bus.state_dbg), 64'(ST_WAIT0));
    c = '{8'hF0, 8'h0F, 8'hAA, 8'h55, 8'hC3, 8'h3C, 8'h99, 8'h66};
    rows(c, 0, GS - 1, 4, 1'b1);

    // multi-hot row select mid-capture
    rows(x_cols, 0, 1, 4, 1'b0);
    put(8'b0000_0110, 8'h5A, 3);
    exp_err++;
    check("multi_err", 64'(err_seen), 64'(exp_err));
    check("multi_state", 64'(bus.state_dbg), 64'(ST_WAIT0));
    check("multi_frame", bus.frame_o, last_frame);
    rows(x_cols, 2, GS - 1, 4, 1'b0);  // ignored in WAIT0

    // blanking between rows, row 4 re-asserted with other data
    c = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    for (int r = 0; r < GS; r++) begin
      if (r > 0) put('0, '0, 2);
      rows(c, r, r, 4, 1'b1);
      if (r == 4) begin
        put('0, '0, 2);
        put(8'b0001_0000, 8'hEE, 4);
      end
    end
    repeat (3) @(negedge clk_i);
    check("rescan_err", 64'(err_seen), 64'(exp_err));

    // enable freeze mid-row
    c = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    rows(c, 0, 2, 4, 1'b0);
    put(8'b0000_1000, c[3], 1);
    en_i = 1'b0;
    put(8'b0000_1000, c[3], 5);
    check("freeze_state", 64'(bus.state_dbg), 64'(ST_CAPT));
    en_i = 1'b1;
    put(8'b0000_1000, c[3], 3);
    rows(c, 4, GS - 1, 4, 1'b1);

    // random scans
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < GS; r++) c[r] = 8'($urandom_range(0, 255));
      rows(c, 0, GS - 1, $urandom_range(2, 5), 1'b1);
    end
    repeat (4) @(negedge clk_i);

    // reset during row 5
    rows(x_cols, 0, 4, 4, 1'b0);
    put(8'b0010_0000, x_cols[5], 1);
    reset_i = 1'b0;
    @(negedge clk_i);
    check("mid_rst_frame", bus.frame_o, '0);
    check("mid_rst_cnt", 64'(bus.frame_cnt_o), 64'd0);
    check("mid_rst_valid", 64'(bus.frame_valid_o), 64'd0);
    check("mid_rst_state", 64'(bus.state_dbg), 64'(ST_WAIT0));
    repeat (2) @(negedge clk_i);
    reset_i   = 1'b1;
    model_cnt = '0;
    rows(x_cols, 0, GS - 1, 4, 1'b1);

    // final report
    repeat (6) @(negedge clk_i);
    check("pending_frames", 64'(exp_q.size()), 64'd0);
    check("seq_err_total", 64'(err_seen), 64'(exp_err));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
